// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - lock input, retry request and supervisor outputs
interface pll_lock_supervisor_if;
    logic       locked;
    logic       retry;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic       lock_lost;
    logic [7:0] loss_count;

    modport master (
        output locked,
        output retry,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fault,
        input  retry_count,
        input  lock_lost,
        input  loss_count
    );

    modport slave (
        input  locked,
        input  retry,
        output pll_rst,
        output sys_rst,
        output ready,
        output fault,
        output retry_count,
        output lock_lost,
        output loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer with retry, fault and lock-loss tracking
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_supervisor_if.slave  bus
);

    if (RST_PULSE_CYCLES < 2 || LOCK_TIMEOUT_CYCLES < 2 || LOCK_STABLE_CYCLES < 2 ||
        MAX_RETRIES < 2 || MAX_RETRIES > 15) begin : g_bad_params
        $error("pll_lock_supervisor: parameter out of range");
    end

    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q;
    logic             locked_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             lock_lost_q, lock_lost_d;
    logic [3:0]       retry_count_q, retry_count_d;
    logic [7:0]       loss_count_q, loss_count_d;

    always_comb begin
        state_d       = state_q;
        retry_count_d = retry_count_q;
        loss_count_d  = loss_count_q;
        lock_lost_d   = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s_q) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_count_q < MAX_R) begin
                        retry_count_d = retry_count_q + 4'd1;
                        state_d       = S_RESET_PLL;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_STABILIZE: begin
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s_q) begin
                    state_d       = S_RESET_PLL;
                    lock_lost_d   = 1'b1;
                    retry_count_d = 4'd0;
                    if (loss_count_q != 8'hFF) begin
                        loss_count_d = loss_count_q + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                if (bus.retry) begin
                    state_d       = S_RESET_PLL;
                    retry_count_d = 4'd0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        // RUN and FAULT hold the counter so it cannot wrap while idling there.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_RESET_PLL || state_q == S_WAIT_LOCK ||
                     state_q == S_STABILIZE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            locked_s_q    <= 1'b0;
            state_q       <= S_RESET_PLL;
            cnt_q         <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
            lock_lost_q   <= 1'b0;
            retry_count_q <= 4'd0;
            loss_count_q  <= 8'd0;
        end else begin
            sync1_q       <= bus.locked;
            locked_s_q    <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_q     <= sys_rst_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
            lock_lost_q   <= lock_lost_d;
            retry_count_q <= retry_count_d;
            loss_count_q  <= loss_count_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.retry_count = retry_count_q;
    assign bus.loss_count  = loss_count_q;

endmodule
